// File: rtl/lifo_stack_param.sv
// lifo_stack_param: parametrised synchronous LIFO stack.
//
// Storage is a DEPTH x DATA_WIDTH register array addressed by the occupancy
// count, which doubles as the stack pointer. The top of stack is entry count-1.
// Pops and replace-top operations load a registered data_out with a one-cycle
// out_valid strobe. A simultaneous push and pop on an empty stack bypasses the
// write data straight to data_out.
//
// Optional feature macro: LIFO_ERR_FLAGS_EN
//   defined   -> overflow / underflow one-cycle pulse ports are present
//   undefined -> those ports and their logic are omitted

module lifo_stack_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_THR     = DEPTH - 1,
    parameter int AE_THR     = 1,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  write_en,
    input  logic                  read_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  out_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count
`ifdef LIFO_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] top_data;
    logic [CW-1:0]         count_next;
    logic                  do_push;
    logic                  do_pop;
    logic                  do_replace;
    logic                  do_bypass;

    // Status flags decode straight from the registered count.
    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (int'(count) >= AF_THR);
    assign almost_empty = (int'(count) <= AE_THR);

    // Classify the request pair against the current occupancy.
    always_comb begin
        do_push    = 1'b0;
        do_pop     = 1'b0;
        do_replace = 1'b0;
        do_bypass  = 1'b0;
        if (write_en && !read_en) begin
            do_push = !full;
        end else if (!write_en && read_en) begin
            do_pop = !empty;
        end else if (write_en && read_en) begin
            do_replace = !empty;
            do_bypass  = empty;
        end
    end

    // Select the top-of-stack entry; comparing the full count avoids an
    // index narrower or wider than the array.
    always_comb begin
        top_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (count == CW'(i + 1)) begin
                top_data = mem[i];
            end
        end
    end

    // Next occupancy; the push/pop qualifiers already exclude full and empty,
    // so the count can neither wrap up nor down.
    always_comb begin
        count_next = count;
        if (do_push) begin
            count_next = count + CW'(1);
        end else if (do_pop) begin
            count_next = count - CW'(1);
        end
    end

    // Entry storage: push writes at count, replace-top overwrites count-1.
    // Contents are intentionally not reset; the count defines what is live.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (do_push && (count == CW'(i))) begin
                    mem[i] <= data_in;
                end else if (do_replace && (count == CW'(i + 1))) begin
                    mem[i] <= data_in;
                end
            end
        end
    end

    // Occupancy register plus the registered pop data and its valid strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count     <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            count     <= count_next;
            out_valid <= do_pop || do_replace || do_bypass;
            if (do_pop || do_replace) begin
                data_out <= top_data;
            end else if (do_bypass) begin
                data_out <= data_in;
            end
        end
    end

`ifdef LIFO_ERR_FLAGS_EN
    // Error pulses last exactly one cycle after the offending edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= write_en && !read_en && full;
            underflow <= read_en && !write_en && empty;
        end
    end
`endif

endmodule

// File: tb/tb_lifo_stack_param.sv
// Self-checking bench for lifo_stack_param: a queue-based stack model is
// compared against the DUT on every falling edge, and directed scenarios add
// hand-computed literal expectations.

module tb_lifo_stack_param;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          write_en = 1'b0;
    logic          read_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          out_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [CW-1:0] count;
`ifdef LIFO_ERR_FLAGS_EN
    logic          overflow;
    logic          underflow;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    lifo_stack_param #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .AF_THR    (6),
        .AE_THR    (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .write_en    (write_en),
        .read_en     (read_en),
        .data_in     (data_in),
        .data_out    (data_out),
        .out_valid   (out_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count)
`ifdef LIFO_ERR_FLAGS_EN
        ,
        .overflow    (overflow),
        .underflow   (underflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue with the top at the back.
    logic [DW-1:0] stk[$];
    logic [DW-1:0] m_dout = '0;
    logic          m_vld  = 1'b0;
    logic          m_ovf  = 1'b0;
    logic          m_udf  = 1'b0;

    always @(posedge clk) begin
        m_vld = 1'b0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        if (!rst_n) begin
            stk.delete();
            m_dout = '0;
        end else if (write_en && read_en) begin
            m_vld = 1'b1;
            if (stk.size() == 0) begin
                m_dout = data_in;
            end else begin
                m_dout = stk[stk.size() - 1];
                stk[stk.size() - 1] = data_in;
            end
        end else if (write_en) begin
            if (stk.size() == DEPTH) m_ovf = 1'b1;
            else stk.push_back(data_in);
        end else if (read_en) begin
            if (stk.size() == 0) begin
                m_udf = 1'b1;
            end else begin
                m_dout = stk.pop_back();
                m_vld  = 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("m_count",     32'(count),        32'(stk.size()));
            chk("m_empty",     32'(empty),        32'(stk.size() == 0));
            chk("m_full",      32'(full),         32'(stk.size() == DEPTH));
            chk("m_afull",     32'(almost_full),  32'(stk.size() >= 6));
            chk("m_aempty",    32'(almost_empty), 32'(stk.size() <= 2));
            chk("m_valid",     32'(out_valid),    32'(m_vld));
            chk("m_data_out",  32'(data_out),     32'(m_dout));
`ifdef LIFO_ERR_FLAGS_EN
            chk("m_overflow",  32'(overflow),     32'(m_ovf));
            chk("m_underflow", 32'(underflow),    32'(m_udf));
`endif
        end
    end

    task automatic step(input logic rn, input logic we, input logic re, input logic [DW-1:0] d);
        rst_n    = rn;
        write_en = we;
        read_en  = re;
        data_in  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] push_vals [7];
        logic [DW-1:0] pop_exp   [7];
        logic          af_exp    [9];
        logic          ae_exp    [9];
        push_vals = '{8'd35, 8'd30, 8'd25, 8'd20, 8'd15, 8'd10, 8'd5};
        pop_exp   = '{8'd5, 8'd10, 8'd15, 8'd20, 8'd25, 8'd30, 8'd35};
        af_exp    = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
        ae_exp    = '{1, 1, 1, 0, 0, 0, 0, 0, 0};

        // Reset state
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk_on = 1'b1;
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full",  32'(full), 32'd0);
        chk("rst_ae",    32'(almost_empty), 32'd1);
        chk("rst_af",    32'(almost_full), 32'd0);
        chk("rst_dout",  32'(data_out), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        step(1'b1, 1'b0, 1'b0, 8'h00);

        // Push/pop order
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, push_vals[i]);
        chk("order_count7", 32'(count), 32'd7);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b0, 1'b1, 8'h00);
            chk("order_dout",  32'(data_out), 32'(pop_exp[i]));
            chk("order_valid", 32'(out_valid), 32'd1);
            chk("order_count", 32'(count), 32'(6 - i));
        end
        step(1'b1, 1'b0, 1'b1, 8'h00);
        chk("order_pop8_valid", 32'(out_valid), 32'd0);
        chk("order_pop8_dout",  32'(data_out), 32'd35);
`ifdef LIFO_ERR_FLAGS_EN
        chk("order_underflow", 32'(underflow), 32'd1);
`endif
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("idle_hold_dout", 32'(data_out), 32'd35);
`ifdef LIFO_ERR_FLAGS_EN
        chk("underflow_pulse_end", 32'(underflow), 32'd0);
`endif

        // Overflow
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 1'b0, DW'(i));
        chk("ovf_full",   32'(full), 32'd1);
        chk("ovf_count8", 32'(count), 32'd8);
        step(1'b1, 1'b1, 1'b0, 8'd99);
        chk("ovf_count_hold", 32'(count), 32'd8);
        chk("ovf_full_hold",  32'(full), 32'd1);
`ifdef LIFO_ERR_FLAGS_EN
        chk("ovf_pulse", 32'(overflow), 32'd1);
`endif
        step(1'b1, 1'b0, 1'b1, 8'h00);
        chk("ovf_pop_dout", 32'(data_out), 32'd8);
`ifdef LIFO_ERR_FLAGS_EN
        chk("ovf_pulse_end", 32'(overflow), 32'd0);
`endif
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1, 8'h00);
        chk("ovf_drained_dout", 32'(data_out), 32'd1);

        // Replace-top
        step(1'b1, 1'b1, 1'b0, 8'd10);
        step(1'b1, 1'b1, 1'b0, 8'd20);
        step(1'b1, 1'b1, 1'b1, 8'd77);
        chk("rep_dout",  32'(data_out), 32'd20);
        chk("rep_count", 32'(count), 32'd2);
        chk("rep_valid", 32'(out_valid), 32'd1);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        chk("rep_pop1", 32'(data_out), 32'd77);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        chk("rep_pop2", 32'(data_out), 32'd10);

        // Empty bypass
        step(1'b1, 1'b1, 1'b1, 8'h5A);
        chk("byp_dout",  32'(data_out), 32'h5A);
        chk("byp_valid", 32'(out_valid), 32'd1);
        chk("byp_count", 32'(count), 32'd0);
        chk("byp_empty", 32'(empty), 32'd1);
`ifdef LIFO_ERR_FLAGS_EN
        chk("byp_no_ovf", 32'(overflow), 32'd0);
        chk("byp_no_udf", 32'(underflow), 32'd0);
`endif
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("byp_valid_drop", 32'(out_valid), 32'd0);

        // Thresholds (AF_THR=6, AE_THR=2)
        for (int c = 1; c <= 8; c++) begin
            step(1'b1, 1'b1, 1'b0, DW'(c));
            chk("thr_up_af", 32'(almost_full), 32'(af_exp[c]));
            chk("thr_up_ae", 32'(almost_empty), 32'(ae_exp[c]));
        end
        for (int c = 7; c >= 0; c--) begin
            step(1'b1, 1'b0, 1'b1, 8'h00);
            chk("thr_dn_af", 32'(almost_full), 32'(af_exp[c]));
            chk("thr_dn_ae", 32'(almost_empty), 32'(ae_exp[c]));
        end

        // Reset mid-operation
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, DW'(8'hA0 + i));
        step(1'b1, 1'b0, 1'b1, 8'h00);
        chk("mid_pre_dout", 32'(data_out), 32'hA3);
        step(1'b0, 1'b1, 1'b0, 8'hEE);
        chk("mid_count", 32'(count), 32'd0);
        chk("mid_empty", 32'(empty), 32'd1);
        chk("mid_dout",  32'(data_out), 32'd0);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        chk("mid_pop_valid", 32'(out_valid), 32'd0);
        chk("mid_pop_count", 32'(count), 32'd0);
`ifdef LIFO_ERR_FLAGS_EN
        chk("mid_underflow", 32'(underflow), 32'd1);
`endif
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
